avmm_multi_timer: RTL and testbench

Parametrised multi-channel Avalon-MM interval timer for the Qsys system, successor to the single-channel 16-bit-bus timer. Provides NUM_CH independent down-counters of CNT_W bits with per-channel prescaler, one-shot/continuous mode, snapshot capture and per-channel interrupt, combined onto one irq line. Sits on the CPU data master as a 32-bit slave with registered read data.

---
 rtl/avmm_multi_timer_pkg.sv | 20 ++
 rtl/avmm_timer_channel.sv | 136 +++++++++++++
 rtl/avmm_multi_timer.sv | 71 +++++++
 tb/tb_avmm_multi_timer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/avmm_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel Avalon-MM timer.
package avmm_multi_timer_pkg;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_CONTROL = 2'd1,
        REG_PERIOD  = 2'd2,
        REG_SNAP    = 2'd3
    } reg_e;

    localparam int STAT_TO      = 0;
    localparam int STAT_RUN     = 1;

    localparam int CTRL_ITO     = 0;
    localparam int CTRL_CONT    = 1;
    localparam int CTRL_START   = 2;
    localparam int CTRL_STOP    = 3;
    localparam int PRESCALE_LSB = 8;

endpackage

// File: rtl/avmm_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags and its four
// bus-visible registers. Read data is combinational; the top registers it.
module avmm_timer_channel
    import avmm_multi_timer_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int          PRE_W        = 8,
    parameter int unsigned RESET_PERIOD = 4999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_i,
    input  logic [1:0]  reg_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
    logic [PRE_W-1:0] pre_q, pre_d, prescale_q, prescale_d;
    logic             ito_q, ito_d, cont_q, cont_d;
    logic             start_q, start_d, stop_q, stop_d;
    logic             run_q, run_d, to_q, to_d;

    logic wr_status, wr_control, wr_period, wr_snap;
    logic start_req, stop_req, tick, event_hit;

    always_comb begin
        wr_status  = wr_i && (reg_i == REG_STATUS);
        wr_control = wr_i && (reg_i == REG_CONTROL);
        wr_period  = wr_i && (reg_i == REG_PERIOD);
        wr_snap    = wr_i && (reg_i == REG_SNAP);
        start_req  = wr_control && wdata_i[CTRL_START];
        stop_req   = wr_control && wdata_i[CTRL_STOP];
        tick       = run_q && (pre_q == '0);
        event_hit  = tick && (cnt_q == '0);

        cnt_d      = cnt_q;
        period_d   = period_q;
        snap_d     = snap_q;
        pre_d      = pre_q;
        prescale_d = prescale_q;
        ito_d      = ito_q;
        cont_d     = cont_q;
        start_d    = start_q;
        stop_d     = stop_q;
        run_d      = run_q;
        to_d       = to_q;

        if (wr_control) begin
            ito_d      = wdata_i[CTRL_ITO];
            cont_d     = wdata_i[CTRL_CONT];
            start_d    = wdata_i[CTRL_START];
            stop_d     = wdata_i[CTRL_STOP];
            prescale_d = wdata_i[PRESCALE_LSB +: PRE_W];
        end
        if (wr_period) period_d = wdata_i[CNT_W-1:0];
        if (wr_snap)   snap_d   = cnt_q;

        // START restarts the prescale interval with the value written alongside it
        if (start_req)
            pre_d = wdata_i[PRESCALE_LSB +: PRE_W];
        else if (run_q)
            pre_d = (pre_q == '0) ? prescale_q : pre_q - PRE_W'(1);

        if (wr_period)
            cnt_d = wdata_i[CNT_W-1:0];
        else if (tick)
            cnt_d = event_hit ? period_q : cnt_q - CNT_W'(1);

        if (start_req)
            run_d = 1'b1;
        else if (stop_req || wr_period)
            run_d = 1'b0;
        else if (event_hit)
            run_d = cont_q;

        // A timeout landing on a STATUS clear must not be lost
        if (event_hit)
            to_d = 1'b1;
        else if (wr_status)
            to_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= RST_CNT;
            period_q   <= RST_CNT;
            snap_q     <= '0;
            pre_q      <= '0;
            prescale_q <= '0;
            ito_q      <= 1'b0;
            cont_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            run_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            snap_q     <= snap_d;
            pre_q      <= pre_d;
            prescale_q <= prescale_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            run_q      <= run_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_e'(reg_i))
            REG_STATUS: begin
                rdata_o[STAT_TO]  = to_q;
                rdata_o[STAT_RUN] = run_q;
            end
            REG_CONTROL: begin
                rdata_o[CTRL_ITO]   = ito_q;
                rdata_o[CTRL_CONT]  = cont_q;
                rdata_o[CTRL_START] = start_q;
                rdata_o[CTRL_STOP]  = stop_q;
                rdata_o[PRESCALE_LSB +: PRE_W] = prescale_q;
            end
            REG_PERIOD: rdata_o = 32'(period_q);
            default:    rdata_o = 32'(snap_q);
        endcase
    end

    assign irq_o = to_q & ito_q;

endmodule

// File: rtl/avmm_multi_timer.sv
// Avalon-MM slave wrapping NUM_CH timer channels: address decode, registered
// read mux and the combined interrupt.
module avmm_multi_timer
    import avmm_multi_timer_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          PRE_W        = 8,
    parameter int unsigned RESET_PERIOD = 4999,
    localparam int         ADDR_W       = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    logic              wr_strobe;
    logic [31:0]       ch_sel;
    logic [NUM_CH-1:0] ch_wr;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [31:0]       readdata_d, readdata_q;

    assign wr_strobe = chipselect & ~write_n;
    assign ch_sel    = 32'(address >> 2);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_wr[gi] = wr_strobe && (ch_sel == 32'(gi));

            avmm_timer_channel #(
                .CNT_W        (CNT_W),
                .PRE_W        (PRE_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .wr_i    (ch_wr[gi]),
                .reg_i   (address[1:0]),
                .wdata_i (writedata),
                .rdata_o (ch_rdata[gi]),
                .irq_o   (irq_vec[gi])
            );
        end
    endgenerate

    // Unpopulated channel slots read back as zero
    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chipselect && (ch_sel == 32'(i)))
                readdata_d = ch_rdata[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata_q <= '0;
        else
            readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule

// File: tb/tb_avmm_multi_timer.sv
// Directed bench for avmm_multi_timer, built with three channels so that
// channel index NUM_CH is addressable.
module tb_avmm_multi_timer;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [2:0]  irq_vec;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    avmm_multi_timer #(.NUM_CH(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Returns on the negedge right after the write edge; cyc then indexes that edge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        step();
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
        $display("WR addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        step();
        chipselect = 1'b1; write_n = 1'b1; address = a;
        step();
        d = readdata;
        chipselect = 1'b0;
        $display("RD addr=%h data=%h", a, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (2) step();
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (irq_vec !== 3'b000) begin errors++; $display("FAIL reset_irq_vec: got %b expected 000", irq_vec); end
        reset_n = 1'b1;
        bus_read(4'b0010, d);
        checks++; if (d !== 32'd4999) begin errors++; $display("FAIL reset_period_ch0: got %0d expected 4999", d); end
        bus_read(4'b0000, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status_ch0: got %h expected 0", d); end
        bus_read(4'b1001, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_control_ch2: got %h expected 0", d); end
    endtask

    task automatic test_continuous();
        int t0;
        logic [31:0] d;
        bus_write(4'b0110, 32'd9);
        bus_write(4'b0101, 32'h0000_0007);
        t0 = cyc;
        while (cyc < t0 + 9) step();
        checks++; if (irq_vec[1] !== 1'b0) begin errors++; $display("FAIL cont_early: got %b expected 0", irq_vec[1]); end
        step();
        checks++; if (irq_vec[1] !== 1'b1) begin errors++; $display("FAIL cont_first_to: got %b expected 1", irq_vec[1]); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cont_irq_first: got %b expected 1", irq); end
        bus_write(4'b0100, 32'd0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_clear: got %b expected 0", irq); end
        while (cyc < t0 + 19) step();
        checks++; if (irq_vec[1] !== 1'b0) begin errors++; $display("FAIL cont_second_early: got %b expected 0", irq_vec[1]); end
        step();
        checks++; if (irq_vec[1] !== 1'b1) begin errors++; $display("FAIL cont_second_to: got %b expected 1", irq_vec[1]); end
        bus_write(4'b0100, 32'd0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_clear2: got %b expected 0", irq); end
        while (cyc < t0 + 28) step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_before_third: got %b expected 0", irq); end
        // STATUS clear lands on the edge of the third timeout
        bus_write(4'b0100, 32'd0);
        checks++; if (irq_vec[1] !== 1'b1) begin errors++; $display("FAIL status_vs_event: got %b expected 1", irq_vec[1]); end
        bus_read(4'b0100, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL cont_status: got %h expected 3", d); end
        bus_write(4'b0101, 32'h0000_0008);
        bus_write(4'b0100, 32'd0);
        bus_read(4'b0100, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL cont_stopped: got %h expected 0", d); end
        bus_read(4'b0101, d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL cont_ctrl_rb: got %h expected 8", d); end
    endtask

    task automatic test_oneshot();
        int t0;
        logic [31:0] d;
        bus_write(4'b1010, 32'd3);
        bus_write(4'b1001, 32'h0000_0405);
        t0 = cyc;
        while (cyc < t0 + 19) step();
        checks++; if (irq_vec[2] !== 1'b0) begin errors++; $display("FAIL oneshot_early: got %b expected 0", irq_vec[2]); end
        step();
        checks++; if (irq_vec[2] !== 1'b1) begin errors++; $display("FAIL oneshot_to: got %b expected 1", irq_vec[2]); end
        bus_read(4'b1000, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL oneshot_status: got %h expected 1", d); end
        bus_read(4'b1001, d);
        checks++; if (d !== 32'h405) begin errors++; $display("FAIL oneshot_ctrl_rb: got %h expected 405", d); end
        bus_write(4'b1000, 32'd0);
        repeat (40) step();
        checks++; if (irq_vec !== 3'b000) begin errors++; $display("FAIL oneshot_no_repeat: got %b expected 000", irq_vec); end
        bus_write(4'b1011, 32'd0);
        bus_read(4'b1011, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL oneshot_hold: got %0d expected 3", d); end
    endtask

    task automatic test_snap_period();
        int t0;
        logic [31:0] d;
        bus_write(4'b0001, 32'h0000_0004);
        t0 = cyc;
        while (cyc < t0 + 8) step();
        // Write edge t0+10 samples the count left by edge t0+9: 4999-9
        bus_write(4'b0011, 32'd0);
        bus_read(4'b0011, d);
        checks++; if (d !== 32'd4990) begin errors++; $display("FAIL snap_mid: got %0d expected 4990", d); end
        bus_write(4'b0010, 32'd100);
        bus_read(4'b0000, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL period_stops: got %h expected 0", d); end
        bus_write(4'b0011, 32'd0);
        bus_read(4'b0011, d);
        checks++; if (d !== 32'd100) begin errors++; $display("FAIL period_reload: got %0d expected 100", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        bus_write(4'b0001, 32'h0000_000C);
        bus_read(4'b0000, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL start_stop_run: got %h expected 2", d); end
        bus_read(4'b0001, d);
        checks++; if (d !== 32'hC) begin errors++; $display("FAIL start_stop_rb: got %h expected c", d); end
        bus_write(4'b0001, 32'h0000_0008);
    endtask

    task automatic test_async_reset();
        int n;
        logic [31:0] d;
        bus_write(4'b0110, 32'd2);
        bus_write(4'b0101, 32'h0000_0007);
        bus_write(4'b1001, 32'h0000_0004);
        n = 0;
        while (irq !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL async_pre_irq: got %b expected 1", irq); end
        chipselect = 1'b1; write_n = 1'b1; address = 4'b0010;
        step();
        checks++; if (readdata !== 32'd100) begin errors++; $display("FAIL async_pre_rd: got %0d expected 100", readdata); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL async_readdata: got %h expected 0", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq: got %b expected 0", irq); end
        checks++; if (irq_vec !== 3'b000) begin errors++; $display("FAIL async_irq_vec: got %b expected 000", irq_vec); end
        step();
        chipselect = 1'b0;
        step();
        reset_n = 1'b1;
        bus_read(4'b0010, d);
        checks++; if (d !== 32'd4999) begin errors++; $display("FAIL async_period: got %0d expected 4999", d); end
        bus_write(4'b0111, 32'd0);
        bus_read(4'b0111, d);
        checks++; if (d !== 32'd4999) begin errors++; $display("FAIL async_counter: got %0d expected 4999", d); end
        bus_read(4'b0100, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL async_status: got %h expected 0", d); end
    endtask

    task automatic test_bad_channel();
        logic [31:0] d;
        bus_write(4'b1110, 32'd7);
        bus_write(4'b1101, 32'h0000_0007);
        bus_read(4'b1110, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL badch_period: got %h expected 0", d); end
        bus_read(4'b1101, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL badch_control: got %h expected 0", d); end
        bus_read(4'b1010, d);
        checks++; if (d !== 32'd4999) begin errors++; $display("FAIL badch_alias: got %0d expected 4999", d); end
        repeat (12) step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL badch_irq: got %b expected 0", irq); end
    endtask

    initial begin
        clk        = 1'b0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        test_reset();
        test_continuous();
        test_oneshot();
        test_snap_period();
        test_simultaneous();
        test_async_reset();
        test_bad_channel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
